mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL take parameters: ADDR_WIDTH, 32, address width from my_pkg; DATA_WIDTH, 32, data width from my_pkg; STARVE_MAX, 4, max consecutive data grants while fetch waits.
REQ-002 SHALL have: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have: rst_n  in  1  synchronous, active-high reset (1 = reset, sampled on rising clk only).
REQ-004 SHALL have: if_req in 1, fetch request; if_addr in ADDR_WIDTH, fetch address.
REQ-005 SHALL have: if_gnt out 1, fetch granted this cycle; if_rvalid out 1, fetch data valid; if_rdata out DATA_WIDTH, fetch data.
REQ-006 SHALL have: d_req in 1; d_we in 1, 1 = store; d_op in 3, mem_op encoding; d_addr in ADDR_WIDTH; d_wdata in DATA_WIDTH.
REQ-007 SHALL have: d_gnt out 1; d_rvalid out 1, load data valid; d_rdata out DATA_WIDTH.
REQ-008 SHALL have: mem_en out 1; mem_we out 1; mem_op out 3; mem_addr out ADDR_WIDTH; mem_wdata out DATA_WIDTH; mem_rdata in DATA_WIDTH, valid one cycle after a mem_en read.
REQ-009 SHALL have: stall out 1, asserted while any request is pending and not granted.

Function
REQ-010 SHALL share one single-port memory between fetch and data; at most one grant per cycle.
REQ-011 SHALL decide grants combinationally in the request cycle; mem_* driven combinationally from the winner.
REQ-012 SHALL give data priority over fetch, except when if_req=1 and starve_cnt==STARVE_MAX, where fetch wins.
REQ-013 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment when d_gnt=1 and if_req=1, saturate at STARVE_MAX, clear to 0 on if_gnt=1 or if_req=0.
REQ-014 Fetch grant SHALL drive mem_en=1, mem_we=0, mem_op=3'b010 (word), mem_addr=if_addr, mem_wdata=0.
REQ-015 Data grant SHALL drive mem_en=1, mem_we=d_we, mem_op=d_op, mem_addr=d_addr, mem_wdata=d_wdata.
REQ-016 No grant SHALL drive mem_en=0, mem_we=0, mem_op=0, mem_addr=0, mem_wdata=0.
REQ-017 SHALL keep registered rsp_owner in {NONE, IF, D}: IF after fetch grant, D after data read grant, NONE after store grant or no grant.
REQ-018 Read latency SHALL be exactly 1 cycle: cycle after grant, owner rvalid=1 for one cycle, owner rdata=mem_rdata.
REQ-019 Non-owner rdata SHALL be 0; stores SHALL produce no rvalid.
REQ-020 SHALL be fully pipelined: new grant allowed in the same cycle an rvalid is presented; sustained 1 grant/cycle.
REQ-021 Requesters hold req and attributes until gnt; arbiter SHALL retain no request state beyond starve_cnt and rsp_owner.
REQ-022 stall SHALL equal (if_req & ~if_gnt) | (d_req & ~d_gnt).
REQ-023 Simultaneous if_req and d_req with starve_cnt<STARVE_MAX: d_gnt=1, if_gnt=0, stall=1.
REQ-024 Req dropped before grant SHALL be ignored without effect on rsp_owner.

Reset
REQ-025 While rst_n=1 at a clk edge: starve_cnt=0, rsp_owner=NONE next cycle.
REQ-026 While rst_n=1: if_gnt=0, d_gnt=0, mem_en=0, mem_we=0, stall=0, regardless of requests.
REQ-027 Cycle after reset released: if_rvalid=0, d_rvalid=0, rdata=0; a read granted in the cycle reset asserts SHALL NOT produce rvalid.
REQ-028 Reset asserted mid-stream SHALL discard pending response and starve state; arbitration resumes the first cycle rst_n=0.

Verification
REQ-029 Fetch only: if_req=1, if_addr=0x100 -> same cycle if_gnt=1, mem_en=1, mem_addr=0x100; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-030 Conflict: if_req=1, d_req=1, d_we=0, d_addr=0x2000 -> d_gnt=1, if_gnt=0, stall=1; next cycle d_rvalid=1, if_rvalid=0.
REQ-031 Starvation, STARVE_MAX=4: both req held high -> d_gnt cycles 1-4, if_gnt cycle 5, starve_cnt back to 0.
REQ-032 Store: d_req=1, d_we=1, d_op=3'b001, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF; no rvalid next cycle.
REQ-033 Back-to-back: fetch granted cycle N, data load cycle N+1 -> if_rvalid at N+1, d_rvalid at N+2, each single-cycle.
REQ-034 Reset mid-read: grant at N, rst_n=1 at N -> no rvalid at N+1; all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch and data.
// Data wins by default; fetch is forced through after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  if_req,
    input  logic [ADDR_WIDTH-1:0]                 if_addr,
    output logic                                  if_gnt,
    output logic                                  if_rvalid,
    output logic [DATA_WIDTH-1:0]                 if_rdata,
    input  logic                                  d_req,
    input  logic                                  d_we,
    input  logic [2:0]                            d_op,
    input  logic [ADDR_WIDTH-1:0]                 d_addr,
    input  logic [DATA_WIDTH-1:0]                 d_wdata,
    output logic                                  d_gnt,
    output logic                                  d_rvalid,
    output logic [DATA_WIDTH-1:0]                 d_rdata,
    output logic                                  mem_en,
    output logic                                  mem_we,
    output logic [2:0]                            mem_op,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    output logic                                  stall,
    output logic [1:0]                            dbg_rsp_owner,
    output logic [$clog2(STARVE_MAX+1)-1:0]       dbg_starve_cnt
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [2:0] OP_WORD = 3'b010;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Handshake: a requester holds req and its attributes until it sees gnt
    // in the same cycle; read data returns with rvalid exactly one cycle later.
    owner_t        rsp_owner;
    logic [CW-1:0] starve_cnt;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        // rst_n is active-high: 1 holds the block in reset.
        if (!rst_n) begin
            if (if_req && (!d_req || starve_cnt == STARVE_LIM)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_op    = 3'b000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_op   = OP_WORD;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_op    = d_op;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rsp_owner  <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            if (if_gnt) begin
                rsp_owner <= OWN_IF;
            end else if (d_gnt && !d_we) begin
                rsp_owner <= OWN_D;
            end else begin
                rsp_owner <= OWN_NONE;
            end

            if (if_gnt || !if_req) begin
                starve_cnt <= '0;
            end else if (d_gnt && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // A response still owed when reset arrives is dropped, not presented.
    assign if_rvalid = (rsp_owner == OWN_IF) && !rst_n;
    assign d_rvalid  = (rsp_owner == OWN_D) && !rst_n;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    assign stall = !rst_n && ((if_req && !if_gnt) || (d_req && !d_gnt));

    assign dbg_rsp_owner  = rsp_owner;
    assign dbg_starve_cnt = starve_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, conflict, starvation, store,
// back-to-back pipelining and reset during an outstanding read.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [2:0]    d_op;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [2:0]    mem_op;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic [1:0]    dbg_rsp_owner;
    logic [2:0]    dbg_starve_cnt;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
        .dbg_rsp_owner(dbg_rsp_owner), .dbg_starve_cnt(dbg_starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_op = 3'b000; d_addr = '0; d_wdata = '0;
    endtask

    initial begin
        rst_n = 1; mem_rdata = '0;
        idle_inputs();

        // Reset holds grants off even with both requests up
        if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h20;
        settle();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_stall", stall, 0);
        tick();
        tick();

        // First cycle out of reset: nothing owed
        rst_n = 0; idle_inputs(); mem_rdata = 32'h5555_AAAA;
        settle();
        chk("post_rst_if_rvalid", if_rvalid, 0);
        chk("post_rst_d_rvalid", d_rvalid, 0);
        chk("post_rst_if_rdata", if_rdata, 0);
        chk("post_rst_d_rdata", d_rdata, 0);
        chk("post_rst_starve", dbg_starve_cnt, 0);
        chk("post_rst_mem_addr", mem_addr, 0);

        // Fetch only
        if_req = 1; if_addr = 32'h100;
        settle();
        chk("fetch_if_gnt", if_gnt, 1);
        chk("fetch_d_gnt", d_gnt, 0);
        chk("fetch_mem_en", mem_en, 1);
        chk("fetch_mem_we", mem_we, 0);
        chk("fetch_mem_op", mem_op, 3'b010);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_stall", stall, 0);
        tick();
        idle_inputs(); mem_rdata = 32'hCAFE_0001;
        settle();
        chk("fetch_if_rvalid", if_rvalid, 1);
        chk("fetch_if_rdata", if_rdata, 32'hCAFE_0001);
        chk("fetch_d_rvalid", d_rvalid, 0);
        chk("fetch_d_rdata", d_rdata, 0);
        chk("idle_mem_en", mem_en, 0);
        tick();
        chk("fetch_rvalid_single", if_rvalid, 0);

        // Conflict: data wins, fetch stalls
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 0; d_op = 3'b010; d_addr = 32'h2000;
        settle();
        chk("conf_d_gnt", d_gnt, 1);
        chk("conf_if_gnt", if_gnt, 0);
        chk("conf_stall", stall, 1);
        chk("conf_mem_addr", mem_addr, 32'h2000);
        tick();
        chk("conf_starve_1", dbg_starve_cnt, 1);
        d_req = 0; mem_rdata = 32'h0000_1234;
        settle();
        chk("conf_d_rvalid", d_rvalid, 1);
        chk("conf_d_rdata", d_rdata, 32'h0000_1234);
        chk("conf_if_rvalid", if_rvalid, 0);
        chk("conf_if_rdata", if_rdata, 0);
        chk("conf_pipe_if_gnt", if_gnt, 1);
        tick();
        if_req = 0; mem_rdata = 32'h0000_5678;
        settle();
        chk("conf_if_rvalid2", if_rvalid, 1);
        chk("conf_if_rdata2", if_rdata, 32'h0000_5678);
        chk("conf_starve_clr", dbg_starve_cnt, 0);
        tick();

        // Starvation: data granted four times, then fetch forced through
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_op = 3'b010; d_addr = 32'h3000;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk($sformatf("starve_d_gnt_%0d", i), d_gnt, 1);
            chk($sformatf("starve_if_gnt_%0d", i), if_gnt, 0);
            chk($sformatf("starve_cnt_%0d", i), dbg_starve_cnt, i - 1);
            tick();
        end
        settle();
        chk("starve_if_gnt_5", if_gnt, 1);
        chk("starve_d_gnt_5", d_gnt, 0);
        chk("starve_stall_5", stall, 1);
        chk("starve_cnt_5", dbg_starve_cnt, 4);
        chk("starve_d_rvalid_5", d_rvalid, 1);
        tick();
        chk("starve_cnt_back", dbg_starve_cnt, 0);
        chk("starve_if_rvalid", if_rvalid, 1);
        chk("starve_d_gnt_again", d_gnt, 1);
        idle_inputs();
        tick();
        tick();

        // Store: write attributes forwarded, no response
        d_req = 1; d_we = 1; d_op = 3'b001; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        settle();
        chk("st_d_gnt", d_gnt, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_op", mem_op, 3'b001);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        idle_inputs(); mem_rdata = 32'h1111_2222;
        settle();
        chk("st_d_rvalid", d_rvalid, 0);
        chk("st_if_rvalid", if_rvalid, 0);
        chk("st_d_rdata", d_rdata, 0);
        tick();

        // Back-to-back fetch then load
        if_req = 1; if_addr = 32'h300;
        settle();
        chk("b2b_if_gnt", if_gnt, 1);
        tick();
        idle_inputs(); d_req = 1; d_addr = 32'h400; d_op = 3'b010; mem_rdata = 32'hAAAA_0001;
        settle();
        chk("b2b_if_rvalid", if_rvalid, 1);
        chk("b2b_if_rdata", if_rdata, 32'hAAAA_0001);
        chk("b2b_d_gnt", d_gnt, 1);
        chk("b2b_d_rvalid_early", d_rvalid, 0);
        tick();
        idle_inputs(); mem_rdata = 32'hBBBB_0002;
        settle();
        chk("b2b_d_rvalid", d_rvalid, 1);
        chk("b2b_d_rdata", d_rdata, 32'hBBBB_0002);
        chk("b2b_if_rvalid_off", if_rvalid, 0);
        tick();
        chk("b2b_d_rvalid_single", d_rvalid, 0);

        // Reset in the grant cycle: no grant, no later response
        rst_n = 1; if_req = 1; if_addr = 32'h500;
        settle();
        chk("rmid_if_gnt", if_gnt, 0);
        chk("rmid_mem_en", mem_en, 0);
        chk("rmid_stall", stall, 0);
        tick();
        rst_n = 0; if_req = 0;
        settle();
        chk("rmid_if_rvalid", if_rvalid, 0);
        chk("rmid_if_rdata", if_rdata, 0);

        // Reset while a response is owed and starvation is built up
        if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h600;
        tick();
        tick();
        chk("rpend_starve_pre", dbg_starve_cnt, 2);
        rst_n = 1;
        settle();
        chk("rpend_d_rvalid", d_rvalid, 0);
        chk("rpend_d_gnt", d_gnt, 0);
        tick();
        rst_n = 0;
        settle();
        chk("rpend_starve_clr", dbg_starve_cnt, 0);
        chk("rpend_d_rvalid_post", d_rvalid, 0);
        chk("rpend_resume_d_gnt", d_gnt, 1);
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
